// File: rtl/eth_sd_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | eth_sd_pkg : shared state encoding and sector geometry constants      |
// | Revision   : 1.0                                                      |
// +-----------------------------------------------------------------------+
package eth_sd_pkg;

  localparam int SECTOR_BYTES         = 512;
  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_WORDS_PER_SECTOR = SECTOR_BYTES / (DEF_DATA_WIDTH / 8);
  localparam int DEF_LBA_WIDTH        = 32;
  localparam int DEF_CNT_WIDTH        = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_STREAM    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/eth_sd_sched_watchdog.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | eth_sd_sched_watchdog : stall counter, present only with              |
// |   ETH_SD_SECTOR_SCHED_TIMEOUT_EN defined                              |
// | Revision              : 1.0                                           |
// +-----------------------------------------------------------------------+
`ifdef ETH_SD_SECTOR_SCHED_TIMEOUT_EN
module eth_sd_sched_watchdog #(
  parameter int LIMIT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic expired
);

  localparam int            CW     = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  // Count resets whenever the watched condition is absent, so each entry starts fresh
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || clear) begin
      r_cnt <= '0;
    end else if (r_cnt != C_LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired = en && !clear && (r_cnt == C_LAST);

endmodule
`endif
`default_nettype wire

// File: rtl/eth_sd_sector_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | eth_sd_sector_sched : drains the prefetch FIFO into SD sector writes  |
// |   optional watchdog: ETH_SD_SECTOR_SCHED_TIMEOUT_EN                   |
// | Revision            : 1.0                                             |
// +-----------------------------------------------------------------------+
module eth_sd_sector_sched
  import eth_sd_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR,
  parameter int LBA_WIDTH        = DEF_LBA_WIDTH,
  parameter int CNT_WIDTH        = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES   = 1000000
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  start,
  input  logic [LBA_WIDTH-1:0]  cfg_start_lba,
  input  logic [CNT_WIDTH-1:0]  cfg_sector_cnt,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  sd_wr_req,
  output logic [LBA_WIDTH-1:0]  sd_wr_lba,
  input  logic                  sd_wr_ack,
  output logic [DATA_WIDTH-1:0] sd_wr_data,
  output logic                  sd_wr_data_vld,
  input  logic                  sd_wr_data_rdy,
  input  logic                  sd_wr_done,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  sectors_written,
  output logic                  err
);

  localparam int                WCNT_W      = $clog2(WORDS_PER_SECTOR);
  localparam logic [WCNT_W-1:0] C_LAST_WORD = WCNT_W'(WORDS_PER_SECTOR - 1);

  sched_state_t         r_state;
  sched_state_t         w_state_next;
  logic [LBA_WIDTH-1:0] r_lba;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] r_sectors_written;
  logic [WCNT_W-1:0]    r_word_cnt;

  logic w_accept;
  logic w_move;
  logic w_last_move;
  logic w_sector_done;
  logic w_timeout;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_move        = (r_state == S_STREAM) && fifo_rd_vld && sd_wr_data_rdy;
  assign w_last_move   = w_move && (r_word_cnt == C_LAST_WORD);
  assign w_sector_done = (r_state == S_WAIT_DONE) && sd_wr_done;

`ifdef ETH_SD_SECTOR_SCHED_TIMEOUT_EN
  logic w_wd_en;
  logic w_wd_clear;
  logic r_err;

  // Any progress (word moved or sector completed) restarts the stall count
  assign w_wd_en    = (r_state == S_STREAM) || (r_state == S_WAIT_DONE);
  assign w_wd_clear = w_move || w_sector_done;

  eth_sd_sched_watchdog #(
    .LIMIT   (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .en      (w_wd_en),
    .clear   (w_wd_clear),
    .expired (w_timeout)
  );

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    fifo_rd_en     = 1'b0;
    sd_wr_req      = 1'b0;
    sd_wr_data     = '0;
    sd_wr_data_vld = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (cfg_sector_cnt == '0) ? S_FINISH : S_REQ;
        end
      end
      S_REQ: begin
        busy      = 1'b1;
        sd_wr_req = 1'b1;
        if (sd_wr_ack) begin
          w_state_next = S_STREAM;
        end
      end
      S_STREAM: begin
        // Pop follows SD readiness; an empty FIFO simply stalls the burst
        busy           = 1'b1;
        fifo_rd_en     = sd_wr_data_rdy;
        sd_wr_data     = fifo_rd_data;
        sd_wr_data_vld = fifo_rd_vld;
        if (w_timeout) begin
          w_state_next = S_FINISH;
        end else if (w_last_move) begin
          w_state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        busy = 1'b1;
        if (w_timeout) begin
          w_state_next = S_FINISH;
        end else if (sd_wr_done) begin
          w_state_next = (r_remaining == CNT_WIDTH'(1)) ? S_FINISH : S_REQ;
        end
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_lba             <= '0;
      r_remaining       <= '0;
      r_sectors_written <= '0;
      r_word_cnt        <= '0;
    end else begin
      if (w_accept) begin
        r_lba             <= cfg_start_lba;
        r_remaining       <= cfg_sector_cnt;
        r_sectors_written <= '0;
      end
      if ((r_state == S_REQ) && sd_wr_ack) begin
        r_word_cnt <= '0;
      end else if (w_move) begin
        r_word_cnt <= r_word_cnt + 1'b1;
      end
      // LBA wraps naturally at 2^LBA_WIDTH
      if (w_sector_done) begin
        r_lba             <= r_lba + 1'b1;
        r_remaining       <= r_remaining - 1'b1;
        r_sectors_written <= r_sectors_written + 1'b1;
      end
    end
  end

  assign sd_wr_lba       = r_lba;
  assign sectors_written = r_sectors_written;

endmodule
`default_nettype wire

// File: tb/tb_eth_sd_sector_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------+
// | tb_eth_sd_sector_sched : FIFO/SD models with data and LBA scoreboard  |
// | Revision               : 1.0                                          |
// +-----------------------------------------------------------------------+
module tb_eth_sd_sector_sched;

  localparam int WPS    = 128;
  localparam int FDEPTH = 2048;

  logic        rd_clk = 1'b0;
  logic        rd_rst;
  logic        start;
  logic [31:0] cfg_start_lba;
  logic [15:0] cfg_sector_cnt;
  logic        fifo_rd_en;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_data;
  logic        sd_wr_req;
  logic [31:0] sd_wr_lba;
  logic        sd_wr_ack;
  logic [31:0] sd_wr_data;
  logic        sd_wr_data_vld;
  logic        sd_wr_data_rdy;
  logic        sd_wr_done;
  logic        busy;
  logic        done;
  logic [15:0] sectors_written;
  logic        err;

  always #5 rd_clk = ~rd_clk;

  eth_sd_sector_sched #(
    .DATA_WIDTH       (32),
    .WORDS_PER_SECTOR (WPS),
    .LBA_WIDTH        (32),
    .CNT_WIDTH        (16),
    .TIMEOUT_CYCLES   (100)
  ) dut (
    .rd_clk          (rd_clk),
    .rd_rst          (rd_rst),
    .start           (start),
    .cfg_start_lba   (cfg_start_lba),
    .cfg_sector_cnt  (cfg_sector_cnt),
    .fifo_rd_en      (fifo_rd_en),
    .fifo_rd_vld     (fifo_rd_vld),
    .fifo_rd_data    (fifo_rd_data),
    .sd_wr_req       (sd_wr_req),
    .sd_wr_lba       (sd_wr_lba),
    .sd_wr_ack       (sd_wr_ack),
    .sd_wr_data      (sd_wr_data),
    .sd_wr_data_vld  (sd_wr_data_vld),
    .sd_wr_data_rdy  (sd_wr_data_rdy),
    .sd_wr_done      (sd_wr_done),
    .busy            (busy),
    .done            (done),
    .sectors_written (sectors_written),
    .err             (err)
  );

  typedef struct {
    logic [31:0] lba;
    int          cnt;
    int          stall_at;
    bit          rand_rdy;
    bit          restart;
    int          exp_sectors;
  } job_t;

  job_t jobs[5];

  int checks   = 0;
  int failures = 0;

  logic [31:0] fmem [0:FDEPTH-1];
  int          wp = 0;
  int          rp = 0;
  logic [31:0] exp_data[$];
  logic [31:0] exp_lba[$];

  int cyc            = 0;
  int pops           = 0;
  int stall_at       = -1;
  int stall_left     = 0;
  bit rand_rdy       = 1'b0;
  bit hold_done      = 1'b0;
  bit pend_pop       = 1'b0;
  int ack_timer      = -1;
  int done_timer     = -1;
  int sec_words      = 0;
  int sector_idx     = 0;
  int done_pulses    = 0;
  int viol           = 0;
  int done_cyc       = 0;
  int last_sdone_cyc = 0;
  int last_move_cyc  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO and SD controller models: drive on the falling edge, observe 1ns later
  always @(negedge rd_clk) begin
    cyc++;
    if (pend_pop) rp++;
    pend_pop   = 1'b0;
    sd_wr_ack  = 1'b0;
    sd_wr_done = 1'b0;
    if (rd_rst) begin
      ack_timer  = -1;
      done_timer = -1;
      sec_words  = 0;
    end else begin
      if (ack_timer == 0) begin
        sd_wr_ack = 1'b1;
        ack_timer = -1;
      end else if (ack_timer > 0) begin
        ack_timer--;
      end
      if (done_timer == 0 && !hold_done) begin
        sd_wr_done     = 1'b1;
        done_timer     = -1;
        sec_words      = 0;
        sector_idx++;
        last_sdone_cyc = cyc;
      end else if (done_timer > 0) begin
        done_timer--;
      end
    end
    if (stall_at >= 0 && pops >= stall_at) begin
      stall_left = 20;
      stall_at   = -1;
    end
    sd_wr_data_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_rd_vld    = (rp != wp) && (stall_left == 0);
    fifo_rd_data   = fmem[rp % FDEPTH];
    if (stall_left > 0) stall_left--;
    #1;
    if (sd_wr_ack) begin
      if (exp_lba.size() == 0) chk("lba_unexpected_req", 1, 0);
      else chk("req_lba", sd_wr_lba, exp_lba.pop_front());
    end
    if (fifo_rd_en && (!busy || sd_wr_req || sec_words >= WPS)) viol++;
    if (fifo_rd_en && fifo_rd_vld) begin
      pend_pop = 1'b1;
      pops++;
    end
    if (sd_wr_data_vld && sd_wr_data_rdy) begin
      if (exp_data.size() == 0) chk("data_extra_word", 1, 0);
      else chk("data", sd_wr_data, exp_data.pop_front());
      sec_words++;
      if (sec_words == WPS) begin
        done_timer    = 3;
        last_move_cyc = cyc;
      end
    end
    if (sd_wr_req && !sd_wr_ack && ack_timer < 0) ack_timer = 3;
    if (done) begin
      done_pulses++;
      done_cyc = cyc;
    end
  end

  task automatic load_job(input logic [31:0] lba, input int cnt);
    logic [31:0] w;
    for (int i = 0; i < cnt * WPS; i++) begin
      w = $urandom;
      fmem[wp % FDEPTH] = w;
      wp++;
      exp_data.push_back(w);
    end
    for (int i = 0; i < cnt; i++) exp_lba.push_back(lba + 32'(i));
    pops        = 0;
    done_pulses = 0;
    viol        = 0;
    sector_idx  = 0;
  endtask

  task automatic pulse_start(input logic [31:0] lba, input int cnt);
    @(negedge rd_clk);
    start          = 1'b1;
    cfg_start_lba  = lba;
    cfg_sector_cnt = 16'(cnt);
    @(negedge rd_clk);
    start          = 1'b0;
    cfg_start_lba  = $urandom;
    cfg_sector_cnt = 16'($urandom);
    #2;
  endtask

  task automatic run_job(input job_t j);
    int n;
    int t0;
    load_job(j.lba, j.cnt);
    stall_at = j.stall_at;
    rand_rdy = j.rand_rdy;
    pulse_start(j.lba, j.cnt);
    t0 = cyc;
    chk("err_after_start", err, 0);
    chk("req_latency", sd_wr_req, j.cnt != 0);
    chk("busy_after_start", busy, j.cnt != 0);
    if (j.restart) begin
      start         = 1'b1;
      cfg_start_lba = 32'hDEAD_0000;
      @(negedge rd_clk);
      start = 1'b0;
      #2;
    end
    n = 0;
    while (done_pulses == 0 && n < 4000) begin
      @(negedge rd_clk);
      #2;
      n++;
    end
    if (done_pulses == 0) begin
      checks++;
      failures++;
      $display("FAIL job_timeout: done pulses 0 after %0d cycles, required 1", n);
    end else if (j.cnt == 0) begin
      chk("zero_cnt_done_latency", (done_cyc - t0) <= 1, 1);
    end else begin
      chk("last_done_to_done", done_cyc - last_sdone_cyc, 1);
    end
    repeat (3) begin
      @(negedge rd_clk);
      #2;
    end
    chk("done_pulse_count", done_pulses, 1);
    chk("sectors_written", sectors_written, j.exp_sectors);
    chk("busy_after_done", busy, 0);
    chk("data_words_left", exp_data.size(), 0);
    chk("lba_reqs_left", exp_lba.size(), 0);
    chk("rd_en_outside_stream", viol, 0);
    stall_at = -1;
    rand_rdy = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, sd_wr_req, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_data_vld"}, sd_wr_data_vld, 0);
    chk({tag, "_data"}, sd_wr_data, 0);
    chk({tag, "_lba"}, sd_wr_lba, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sectors"}, sectors_written, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    job_t jr;
    int   n;
    rd_rst         = 1'b1;
    start          = 1'b0;
    cfg_start_lba  = '0;
    cfg_sector_cnt = '0;
    fifo_rd_vld    = 1'b0;
    fifo_rd_data   = '0;
    sd_wr_ack      = 1'b0;
    sd_wr_data_rdy = 1'b0;
    sd_wr_done     = 1'b0;

    jobs[0] = '{lba: 32'h0000_0100, cnt: 2, stall_at: -1, rand_rdy: 1'b0, restart: 1'b0, exp_sectors: 2};
    jobs[1] = '{lba: 32'hFFFF_FFFF, cnt: 2, stall_at: -1, rand_rdy: 1'b0, restart: 1'b0, exp_sectors: 2};
    jobs[2] = '{lba: 32'h0000_0055, cnt: 1, stall_at: 60, rand_rdy: 1'b1, restart: 1'b0, exp_sectors: 1};
    jobs[3] = '{lba: 32'h0000_0020, cnt: 0, stall_at: -1, rand_rdy: 1'b0, restart: 1'b0, exp_sectors: 0};
    jobs[4] = '{lba: 32'h0000_0007, cnt: 3, stall_at: -1, rand_rdy: 1'b1, restart: 1'b1, exp_sectors: 3};

    repeat (3) @(negedge rd_clk);
    #2;
    chk_all_zero("reset");
    @(negedge rd_clk);
    rd_rst = 1'b0;

    for (int i = 0; i < 5; i++) run_job(jobs[i]);

    // Reset in the middle of the second sector, then a clean job
    load_job(32'h0000_0300, 2);
    pulse_start(32'h0000_0300, 2);
    n = 0;
    while (!(sector_idx == 1 && sec_words >= 40) && n < 3000) begin
      @(negedge rd_clk);
      #2;
      n++;
    end
    chk("midjob_reached_word40", (sector_idx == 1 && sec_words >= 40), 1);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    #2;
    chk_all_zero("midjob_reset");
    @(negedge rd_clk);
    rd_rst = 1'b0;
    rp         = wp;
    ack_timer  = -1;
    done_timer = -1;
    sec_words  = 0;
    exp_data.delete();
    exp_lba.delete();
    jr = '{lba: 32'h0000_0400, cnt: 1, stall_at: -1, rand_rdy: 1'b0, restart: 1'b0, exp_sectors: 1};
    run_job(jr);

`ifdef ETH_SD_SECTOR_SCHED_TIMEOUT_EN
    // Withheld sector completion must trip the watchdog
    load_job(32'h0000_0010, 1);
    hold_done = 1'b1;
    pulse_start(32'h0000_0010, 1);
    n = 0;
    while (!err && n < 1000) begin
      @(negedge rd_clk);
      #2;
      n++;
    end
    chk("timeout_err", err, 1);
    chk("timeout_done_latency", done_cyc - last_move_cyc, 101);
    repeat (2) begin
      @(negedge rd_clk);
      #2;
    end
    chk("timeout_done_pulses", done_pulses, 1);
    chk("timeout_busy", busy, 0);
    chk("timeout_err_sticky", err, 1);
    hold_done  = 1'b0;
    done_timer = -1;
    sec_words  = 0;
    jr = '{lba: 32'h0000_0500, cnt: 1, stall_at: -1, rand_rdy: 1'b0, restart: 1'b0, exp_sectors: 1};
    run_job(jr);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
